// File: rtl/ofdm_sync_pkg.sv
// Shared definitions for the OFDM preamble synchronisation stages:
// detector state encoding and default window/holdoff lengths.
package ofdm_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        HOLDOFF = 2'd2
    } sync_state_e;

    localparam int WIN_LEN_DEF     = 16;
    localparam int HOLDOFF_LEN_DEF = 80;

endpackage

// File: rtl/preamble_peak_detector_if.sv
// Sample stream in, detection report out, for the preamble peak detector.
interface preamble_peak_detector_if #(
    parameter int DATA_SIZE = 16,
    parameter int CNT_W     = 16
);
    logic                 en;
    logic [DATA_SIZE-1:0] in_corr;
    logic [DATA_SIZE-1:0] in_porog;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_peak;
    logic [CNT_W-1:0]     out_index;
    logic                 out_busy;

    modport master (
        output en, in_corr, in_porog,
        input  out_valid, out_peak, out_index, out_busy
    );

    modport slave (
        input  en, in_corr, in_porog,
        output out_valid, out_peak, out_index, out_busy
    );
endinterface

// File: rtl/preamble_peak_detector_peak_tracker.sv
// Running maximum of the search window with the index where it occurred.
// Strict-greater compare, so the earliest of equal samples is kept.
module peak_tracker #(
    parameter int DATA_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 update,
    input  logic [DATA_SIZE-1:0] in_corr,
    input  logic [CNT_W-1:0]     in_idx,
    output logic                 better,
    output logic [DATA_SIZE-1:0] peak_nxt,
    output logic [CNT_W-1:0]     idx_nxt
);
    logic [DATA_SIZE-1:0] peak_q, peak_d;
    logic [CNT_W-1:0]     idx_q, idx_d;

    assign better = in_corr > peak_q;

    always_comb begin
        peak_d = peak_q;
        idx_d  = idx_q;
        if (init || update) begin
            peak_d = in_corr;
            idx_d  = in_idx;
        end
    end

    // The next value is exported so a closing sample can be reported on its own edge.
    assign peak_nxt = peak_d;
    assign idx_nxt  = idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
            idx_q  <= '0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/preamble_peak_detector.sv
// Preamble peak detector: threshold crossing opens a search window, the largest
// sample in it is reported once, then further detections are held off.
module preamble_peak_detector
    import ofdm_sync_pkg::*;
#(
    parameter int DATA_SIZE      = 16,
    parameter int CNT_W          = 16,
    parameter int WIN_LEN        = WIN_LEN_DEF,
    parameter int MAX_SEARCH_LEN = 64,
    parameter int HOLDOFF_LEN    = HOLDOFF_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    preamble_peak_detector_if.slave  bus
);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int SRCH_W = $clog2(MAX_SEARCH_LEN + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_LEN + 1);

    sync_state_e          state_q, state_d;
    logic [CNT_W-1:0]     sample_idx_q, sample_idx_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [SRCH_W-1:0]    search_cnt_q, search_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0] out_peak_q, out_peak_d;
    logic [CNT_W-1:0]     out_index_q, out_index_d;
    logic                 out_busy_q, out_busy_d;

    logic                 trk_init, trk_update, trk_better;
    logic [DATA_SIZE-1:0] trk_peak_nxt;
    logic [CNT_W-1:0]     trk_idx_nxt;

    peak_tracker #(.DATA_SIZE(DATA_SIZE), .CNT_W(CNT_W)) u_peak_tracker (
        .clk      (clk),
        .rst      (rst),
        .init     (trk_init),
        .update   (trk_update),
        .in_corr  (bus.in_corr),
        .in_idx   (sample_idx_q),
        .better   (trk_better),
        .peak_nxt (trk_peak_nxt),
        .idx_nxt  (trk_idx_nxt)
    );

    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        win_cnt_d    = win_cnt_q;
        search_cnt_d = search_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        out_valid_d  = 1'b0;
        out_peak_d   = out_peak_q;
        out_index_d  = out_index_q;
        out_busy_d   = out_busy_q;
        trk_init     = 1'b0;
        trk_update   = 1'b0;

        if (bus.en) begin
            sample_idx_d = sample_idx_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (bus.in_corr > bus.in_porog) begin
                        state_d      = SEARCH;
                        trk_init     = 1'b1;
                        win_cnt_d    = '0;
                        search_cnt_d = SRCH_W'(1);
                    end
                end
                SEARCH: begin
                    search_cnt_d = search_cnt_q + SRCH_W'(1);
                    if (trk_better) begin
                        trk_update = 1'b1;
                        win_cnt_d  = '0;
                    end else begin
                        win_cnt_d  = win_cnt_q + WIN_W'(1);
                    end
                    if (win_cnt_d == WIN_W'(WIN_LEN) ||
                        search_cnt_d >= SRCH_W'(MAX_SEARCH_LEN)) begin
                        out_valid_d = 1'b1;
                        out_peak_d  = trk_peak_nxt;
                        out_index_d = trk_idx_nxt;
                        hold_cnt_d  = '0;
                        state_d     = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == HOLD_W'(HOLDOFF_LEN)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            out_busy_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_idx_q <= '0;
            win_cnt_q    <= '0;
            search_cnt_q <= '0;
            hold_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_peak_q   <= '0;
            out_index_q  <= '0;
            out_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_idx_q <= sample_idx_d;
            win_cnt_q    <= win_cnt_d;
            search_cnt_q <= search_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            out_valid_q  <= out_valid_d;
            out_peak_q   <= out_peak_d;
            out_index_q  <= out_index_d;
            out_busy_q   <= out_busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_peak  = out_peak_q;
    assign bus.out_index = out_index_q;
    assign bus.out_busy  = out_busy_q;
endmodule

// File: tb/tb_preamble_peak_detector.sv
// Bench for preamble_peak_detector: directed scenarios with literal expectations
// plus a randomized run, all compared cycle by cycle against a queue-based model.
module tb_preamble_peak_detector;
    localparam int WIN  = 4;
    localparam int MAXS = 8;
    localparam int HOLD = 6;

    logic clk;
    logic rst;

    preamble_peak_detector_if #(.DATA_SIZE(16), .CNT_W(16)) bus ();

    preamble_peak_detector #(
        .DATA_SIZE(16), .CNT_W(16), .WIN_LEN(WIN),
        .MAX_SEARCH_LEN(MAXS), .HOLDOFF_LEN(HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: the open search is a list of (value, index); the report is its
    // earliest maximum, closed by trailing-run length or list length.
    logic [15:0] m_idx;
    int          m_mode;   // 0 idle, 1 searching, 2 holding off
    int          m_hold;
    int          q_val[$];
    logic [15:0] q_idx[$];
    logic        exp_valid, exp_busy;
    logic [15:0] exp_peak, exp_index;

    int          rep_cnt;
    logic [15:0] rep_peak, rep_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply();
        logic [15:0] cur;
        int best;
        if (rst) begin
            m_idx = '0; m_mode = 0; m_hold = 0;
            q_val.delete(); q_idx.delete();
            exp_valid = 0; exp_busy = 0; exp_peak = '0; exp_index = '0;
        end else begin
            exp_valid = 0;
            if (bus.en) begin
                cur   = m_idx;
                m_idx = m_idx + 16'd1;
                if (m_mode == 0) begin
                    if (bus.in_corr > bus.in_porog) begin
                        m_mode = 1;
                        q_val.delete(); q_idx.delete();
                        q_val.push_back(int'(bus.in_corr));
                        q_idx.push_back(cur);
                    end
                end else if (m_mode == 1) begin
                    q_val.push_back(int'(bus.in_corr));
                    q_idx.push_back(cur);
                    best = 0;
                    for (int i = 1; i < q_val.size(); i++)
                        if (q_val[i] > q_val[best]) best = i;
                    if ((q_val.size() - 1 - best) >= WIN || q_val.size() >= MAXS) begin
                        exp_valid = 1;
                        exp_peak  = 16'(q_val[best]);
                        exp_index = q_idx[best];
                        m_mode    = 2;
                        m_hold    = HOLD;
                    end
                end else begin
                    m_hold--;
                    if (m_hold == 0) m_mode = 0;
                end
                exp_busy = (m_mode != 0);
            end
        end
    endtask

    task automatic cmp_all();
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("out_peak",  32'(bus.out_peak),  32'(exp_peak));
        check("out_index", 32'(bus.out_index), 32'(exp_index));
        check("out_busy",  32'(bus.out_busy),  32'(exp_busy));
        if (bus.out_valid === 1'b1) begin
            rep_cnt++;
            rep_peak = bus.out_peak;
            rep_idx  = bus.out_index;
        end
    endtask

    task automatic step(input logic e, input int c, input int p);
        bus.en       = e;
        bus.in_corr  = 16'(c);
        bus.in_porog = 16'(p);
        @(posedge clk);
        model_apply();
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 256);
        rst = 1'b0;
    endtask

    int seq1[7] = '{100, 300, 500, 400, 200, 200, 200};
    int seq2[7] = '{300, 600, 600, 0, 0, 0, 0};
    int r0;

    initial begin
        rst = 1'b0; rep_cnt = 0; rep_peak = '0; rep_idx = '0;
        bus.en = 1'b0; bus.in_corr = '0; bus.in_porog = '0;
        m_idx = '0; m_mode = 0; m_hold = 0;
        exp_valid = 0; exp_busy = 0; exp_peak = '0; exp_index = '0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_busy",  32'(bus.out_busy), 0);
        check("rst_peak",  32'(bus.out_peak), 0);

        // Basic peak, exact latency
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq1[i], 256);
            if (i == 5) check("t1_early", 32'(bus.out_valid), 0);
        end
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_peak",  32'(bus.out_peak), 500);
        check("t1_index", 32'(bus.out_index), 2);

        // Holdoff: six strong samples are ignored, the seventh opens a search
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 900, 256);
            check("t4_noreport", 32'(bus.out_valid), 0);
        end
        check("t4_idle_after_hold", 32'(bus.out_busy), 0);
        step(1'b1, 900, 256);
        check("t4_search", 32'(bus.out_busy), 1);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 256);
        check("t4_peak",  32'(bus.out_peak), 900);
        check("t4_index", 32'(bus.out_index), 13);
        for (int i = 0; i < 6; i++) step(1'b1, 0, 256);

        // Tie: earliest wins
        do_reset();
        r0 = rep_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, seq2[i], 256);
        check("t2_count", 32'(rep_cnt - r0), 1);
        check("t2_peak",  32'(rep_peak), 600);
        check("t2_index", 32'(rep_idx), 1);

        // Search length cap
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 300 + 10 * i, 256);
        check("t3_valid", 32'(bus.out_valid), 1);
        check("t3_peak",  32'(bus.out_peak), 370);
        check("t3_index", 32'(bus.out_index), 7);

        // en gaps
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq1[i], 256);
            if (i < 6) step(1'b0, int'($urandom_range(0, 2000)), 256);
        end
        check("t5_valid", 32'(bus.out_valid), 1);
        check("t5_peak",  32'(bus.out_peak), 500);
        check("t5_index", 32'(bus.out_index), 2);
        step(1'b0, 0, 256);
        check("t5_pulse", 32'(bus.out_valid), 0);

        // Reset mid-search, then threshold-equal and index restart
        do_reset();
        r0 = rep_cnt;
        for (int i = 0; i < 3; i++) step(1'b1, seq1[i], 256);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 0, 256);
        check("t6_noreport", 32'(rep_cnt - r0), 0);
        do_reset();
        step(1'b1, 256, 256);
        check("t6_equal_idle", 32'(bus.out_busy), 0);
        step(1'b1, 300, 256);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 256);
        check("t6_restart_idx", 32'(rep_idx), 1);

        // Randomized run with coarse values so ties are frequent
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 15)) * 32,
                      int'($urandom_range(200, 320)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
